imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader_byte_packer.sv | 52 +++++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      PAYLOAD,
      CSUM,
      RUN,
      ERROR
   } loader_state_t;

   localparam int         BYTES_PER_WORD = 4;
   localparam logic [7:0] CSUM_GOOD      = 8'h00;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs big-endian payload bytes into 32-bit words; word_valid pulses the cycle
// after the final byte of a word is taken.
module imem_loader_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        clr_n,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        last_byte,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int IDX_W = $clog2(BYTES_PER_WORD);

   logic [IDX_W-1:0] idx_q, idx_d;
   logic [31:0]      shift_q, shift_d;
   logic             valid_q, valid_d;

   assign last_byte  = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
   assign word_valid = valid_q;
   assign word       = shift_q;

   // The shift register is left alone on clear so a write already on the bus stays intact.
   always_comb begin
      idx_d   = idx_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      if (clear) begin
         idx_d = '0;
      end else if (byte_valid) begin
         shift_d = {shift_q[23:0], byte_data};
         idx_d   = idx_q + IDX_W'(1);
         valid_d = last_byte;
      end
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         idx_q   <= '0;
         shift_q <= '0;
         valid_q <= 1'b0;
      end else begin
         idx_q   <= idx_d;
         shift_q <= shift_d;
         valid_q <= valid_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed, checksummed byte stream, writes instruction memory,
// then releases the core through cpu_run.
//
// state   | meaning
// HDR_HI  | waiting for word-count high byte (no timeout)
// HDR_LO  | waiting for word-count low byte
// PAYLOAD | streaming N words, four bytes each
// CSUM    | waiting for the checksum byte
// RUN     | frame good, core released, stream ignored
// ERROR   | bad length, checksum or timeout; stream ignored
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 1_000_000
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic              reload,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              load_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int          TMR_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [16:0] MAX_WORDS = 17'(1 << ADDR_W);

   loader_state_t     state_q, state_d;
   logic [15:0]       n_q, n_d;
   logic [7:0]        sum_q, sum_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   count_inc;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic              rdy_q, rdy_d;
   logic              run_q, run_d;
   logic              err_q, err_d;

   logic              accept;
   logic              counting;
   logic              timeout_hit;
   logic [7:0]        sum_next;
   logic [15:0]       n_rx;
   logic              last_byte;

   assign rx_ready    = rdy_q & ~reload;
   assign accept      = rx_valid & rx_ready;
   assign sum_next    = sum_q + rx_data;
   assign n_rx        = {n_q[15:8], rx_data};
   assign count_inc   = count_q + (ADDR_W+1)'(1);
   assign counting    = (state_q == HDR_LO) || (state_q == PAYLOAD) || (state_q == CSUM);
   // Down-counter reloads on every accepted byte; expiry is the T-th consecutive idle cycle.
   assign timeout_hit = (TIMEOUT != 0) && counting && !accept && (tmr_q == TMR_W'(1));

   assign mem_addr   = addr_q;
   assign cpu_run    = run_q;
   assign load_err   = err_q;
   assign word_count = count_q;

   imem_loader_byte_packer u_packer (
      .clk        (clk),
      .clr_n      (clr_n),
      .clear      (reload),
      .byte_valid (accept && (state_q == PAYLOAD)),
      .byte_data  (rx_data),
      .last_byte  (last_byte),
      .word_valid (mem_wen),
      .word       (mem_wdata)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      sum_d   = sum_q;
      count_d = count_q;
      addr_d  = addr_q;
      tmr_d   = tmr_q;

      if (accept) begin
         sum_d = sum_next;
      end
      if (accept || (state_q == HDR_HI)) begin
         tmr_d = TMR_W'(TIMEOUT);
      end else if (tmr_q != '0) begin
         tmr_d = tmr_q - TMR_W'(1);
      end

      case (state_q)
         HDR_HI: begin
            if (accept) begin
               n_d[15:8] = rx_data;
               state_d   = HDR_LO;
            end
         end
         HDR_LO: begin
            if (accept) begin
               n_d[7:0] = rx_data;
               if ({1'b0, n_rx} > MAX_WORDS) begin
                  state_d = ERROR;
               end else if (n_rx == 16'd0) begin
                  state_d = CSUM;
               end else begin
                  state_d = PAYLOAD;
               end
            end
         end
         PAYLOAD: begin
            if (accept && last_byte) begin
               addr_d  = count_q[ADDR_W-1:0];
               count_d = count_inc;
               if (32'(count_inc) == 32'(n_q)) begin
                  state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (accept) begin
               state_d = (sum_next == CSUM_GOOD) ? RUN : ERROR;
            end
         end
         default: ;
      endcase

      if (timeout_hit) begin
         state_d = ERROR;
      end

      if (reload) begin
         state_d = HDR_HI;
         n_d     = '0;
         sum_d   = '0;
         count_d = '0;
         tmr_d   = TMR_W'(TIMEOUT);
      end

      rdy_d = (state_d == HDR_HI) || (state_d == HDR_LO) ||
              (state_d == PAYLOAD) || (state_d == CSUM);
      run_d = (state_d == RUN);
      err_d = (state_d == ERROR);
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= HDR_HI;
         n_q     <= '0;
         sum_q   <= '0;
         count_q <= '0;
         addr_q  <= '0;
         tmr_q   <= TMR_W'(TIMEOUT);
         rdy_q   <= 1'b0;
         run_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         tmr_q   <= tmr_d;
         rdy_q   <= rdy_d;
         run_q   <= run_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are modelled as byte queues, expected
// memory writes are queued up front and checked by an independent write monitor.
module tb_imem_loader;

   localparam int ADDR_W  = 8;
   localparam int TIMEOUT = 16;
   localparam int DEPTH   = 1 << ADDR_W;

   typedef logic [7:0] bq_t[$];
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk      = 1'b0;
   logic              clr_n    = 1'b0;
   logic [7:0]        rx_data  = 8'h00;
   logic              rx_valid = 1'b0;
   logic              reload   = 1'b0;
   logic              rx_ready;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_run;
   logic              load_err;
   logic [ADDR_W:0]   word_count;

   int  tests     = 0;
   int  fails     = 0;
   int  stalls    = 0;
   bit  stall_chk = 1'b0;
   wr_t exp_q[$];
   wr_t mon_e;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .reload     (reload),
      .mem_wen    (mem_wen),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_run    (cpu_run),
      .load_err   (load_err),
      .word_count (word_count)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (clr_n && mem_wen) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0d data %08h, expected no write", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", 64'(mem_addr), 64'(mon_e.addr));
            check("write_data", 64'(mem_wdata), 64'(mon_e.data));
         end
      end
   end

   // Called just after a negedge; returns at the negedge following acceptance.
   task automatic send_byte(input logic [7:0] b);
      bit acc;
      bit ok;
      int guard;
      ok       = 1'b0;
      guard    = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!ok && guard < 64) begin
         #1 acc = rx_ready;
         if (!acc && stall_chk) stalls++;
         @(negedge clk);
         guard++;
         ok = acc;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: byte %02h not accepted, rx_ready %b, expected 1", b, rx_ready);
      end
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reload();
      @(negedge clk);
      rx_valid = 1'b0;
      reload   = 1'b1;
      #1 check("reload_blocks_ready", 64'(rx_ready), 64'd0);
      @(negedge clk);
      reload = 1'b0;
      #1;
      check("reload_cpu_run", 64'(cpu_run), 64'd0);
      check("reload_load_err", 64'(load_err), 64'd0);
      check("reload_word_count", 64'(word_count), 64'd0);
      check("reload_rx_ready", 64'(rx_ready), 64'd1);
   endtask

   function automatic bq_t make_frame(input int n, input bit bad);
      bq_t  f;
      logic [7:0] s;
      f.push_back(8'(n >> 8));
      f.push_back(8'(n));
      for (int i = 0; i < n * 4; i++) f.push_back(8'($urandom_range(255, 0)));
      s = 8'h00;
      foreach (f[i]) s = s + f[i];
      f.push_back(8'(0 - s) + (bad ? 8'h01 : 8'h00));
      return f;
   endfunction

   // Reference: N from header, oversize rejects after the header, otherwise all
   // N words are written and the frame is good iff the byte sum is 0 mod 256.
   task automatic run_frame(input bq_t f, input int gap_max, input string tag);
      int  n;
      int  sum;
      int  nsend;
      bit  over;
      bit  good;
      wr_t w;
      n     = {f[0], f[1]};
      over  = (n > DEPTH);
      nsend = over ? 2 : f.size();
      sum   = 0;
      foreach (f[i]) sum += f[i];
      good  = !over && ((sum % 256) == 0);
      if (!over) begin
         for (int i = 0; i < n; i++) begin
            w.addr = ADDR_W'(i);
            w.data = {f[2+4*i], f[3+4*i], f[4+4*i], f[5+4*i]};
            exp_q.push_back(w);
         end
      end
      for (int i = 0; i < nsend; i++) begin
         send_byte(f[i]);
         if (gap_max > 0 && i < nsend - 1) idle($urandom_range(gap_max, 0));
      end
      idle(3);
      #1;
      check({tag, "_cpu_run"}, 64'(cpu_run), 64'(good));
      check({tag, "_load_err"}, 64'(load_err), 64'(!good));
      check({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
      check({tag, "_word_count"}, 64'(word_count), over ? 64'd0 : 64'(n));
      check({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t f;
      #1;
      check("rst_rx_ready", 64'(rx_ready), 64'd0);
      check("rst_cpu_run", 64'(cpu_run), 64'd0);
      check("rst_load_err", 64'(load_err), 64'd0);
      check("rst_mem_wen", 64'(mem_wen), 64'd0);
      check("rst_word_count", 64'(word_count), 64'd0);
      repeat (2) @(negedge clk);
      clr_n = 1'b1;

      f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD2};
      run_frame(f, 0, "one_word");

      do_reload();
      f = '{8'h00, 8'h00};
      send_byte(f[0]);
      send_byte(f[1]);
      send_byte(8'h00);
      rx_valid = 1'b0;
      #1 check("n0_cpu_run_next_cycle", 64'(cpu_run), 64'd1);
      idle(2);
      #1 check("n0_word_count", 64'(word_count), 64'd0);
      check("n0_load_err", 64'(load_err), 64'd0);

      do_reload();
      f = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'hD3};
      run_frame(f, 0, "bad_csum");

      do_reload();
      f = '{8'h01, 8'h01};
      run_frame(f, 0, "oversize");

      do_reload();
      f = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
      foreach (f[i]) send_byte(f[i]);
      idle(TIMEOUT - 1);
      #1 check("timeout_before", 64'(load_err), 64'd0);
      idle(1);
      #1 check("timeout_err", 64'(load_err), 64'd1);
      check("timeout_rx_ready", 64'(rx_ready), 64'd0);
      check("timeout_no_write", 64'(word_count), 64'd0);
      do_reload();
      run_frame(make_frame(2, 1'b0), 2, "after_timeout");

      for (int k = 0; k < 6; k++) begin
         do_reload();
         run_frame(make_frame($urandom_range(8, 1), ($urandom_range(3, 0) == 0)), 3, "random");
      end

      do_reload();
      stall_chk = 1'b1;
      stalls    = 0;
      run_frame(make_frame(DEPTH, 1'b0), 0, "full_depth");
      stall_chk = 1'b0;
      check("full_depth_stalls", 64'(stalls), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
